// File: rtl/fetch_decode_ctrl.sv
// Front-end control slice: fetch PC register, PC+4 adder, opcode decode,
// Decode-stage branch resolution and the D->E control pipeline register.
// Latency: PCSRC_D/PCBRANCH_D/PCPLUS4_F are combinational; *_E one cycle after INSTR_D.
// Backpressure: STALL freezes PC_F and the *_E register; FLUSH_E loads a bubble and beats STALL.
//
// Ports:
//   CLK, RESET (async, active-high)
//   STALL, FLUSH_E, INSTR_D, PCPLUS4_D, RD1_D, RD2_D
//   PC_F, PCPLUS4_F, PCSRC_D, PCBRANCH_D
//   REG_WRITE_E, MEM_TO_REG_E, MEM_WRITE_E, ALU_SRC_E, REG_DST_E, ALU_CONTROL_E, ILLEGAL_E
//
// Build option: define VECTOR_OPS_EN to allow vector R-type ops (ALU_CONTROL[3] = VEC).
// Without it, an R-type with VEC=1 is reported as illegal.
module fetch_decode_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             FLUSH_E,
  input  logic [31:0]      INSTR_D,
  input  logic [WIDTH-1:0] PCPLUS4_D,
  input  logic [WIDTH-1:0] RD1_D,
  input  logic [WIDTH-1:0] RD2_D,
  output logic [WIDTH-1:0] PC_F,
  output logic [WIDTH-1:0] PCPLUS4_F,
  output logic             PCSRC_D,
  output logic [WIDTH-1:0] PCBRANCH_D,
  output logic             REG_WRITE_E,
  output logic             MEM_TO_REG_E,
  output logic             MEM_WRITE_E,
  output logic             ALU_SRC_E,
  output logic             REG_DST_E,
  output logic [3:0]       ALU_CONTROL_E,
  output logic             ILLEGAL_E
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_control;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [5:0]       op;
  logic [2:0]       shift;
  logic             vec;
  logic [15:0]      imm;
  logic [WIDTH-1:0] imm_sext;
  logic             branch;
  logic             equal;
  ctrl_t            dec;
  ctrl_t            ctrl_e;
  logic             unused_instr_bits;

  assign op    = INSTR_D[31:26];
  assign shift = INSTR_D[3:1];
  assign vec   = INSTR_D[0];
  assign imm   = INSTR_D[15:0];

  // Register-field bits are consumed by the register file, not by this slice.
  assign unused_instr_bits = ^INSTR_D[25:16];

  // Control unit
  always_comb begin
    dec    = '0;
    branch = 1'b0;
    case (op)
      OP_RTYPE: begin
`ifdef VECTOR_OPS_EN
        dec.reg_write   = 1'b1;
        dec.reg_dst     = 1'b1;
        dec.alu_control = {vec, shift};
`else
        // Vector ops not built in: reject outright so nothing gets written.
        if (vec) begin
          dec.illegal = 1'b1;
        end else begin
          dec.reg_write   = 1'b1;
          dec.reg_dst     = 1'b1;
          dec.alu_control = {1'b0, shift};
        end
`endif
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        branch          = 1'b1;
        dec.alu_control = 4'b0001;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Branch resolution in Decode
  assign imm_sext   = {{(WIDTH-16){imm[15]}}, imm};
  assign equal      = (RD1_D == RD2_D);
  assign PCSRC_D    = branch & equal;
  assign PCBRANCH_D = PCPLUS4_D + (imm_sext << 2);

  // Fetch PC; carry out of the adder is dropped so the PC wraps.
  assign PCPLUS4_F = PC_F + WIDTH'(4);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC_F <= '0;
    end else if (!STALL) begin
      PC_F <= PCSRC_D ? PCBRANCH_D : PCPLUS4_F;
    end
  end

  // D->E control register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctrl_e <= '0;
    end else if (FLUSH_E) begin
      ctrl_e <= '0;
    end else if (!STALL) begin
      ctrl_e <= dec;
    end
  end

  assign REG_WRITE_E   = ctrl_e.reg_write;
  assign MEM_TO_REG_E  = ctrl_e.mem_to_reg;
  assign MEM_WRITE_E   = ctrl_e.mem_write;
  assign ALU_SRC_E     = ctrl_e.alu_src;
  assign REG_DST_E     = ctrl_e.reg_dst;
  assign ALU_CONTROL_E = ctrl_e.alu_control;
  assign ILLEGAL_E     = ctrl_e.illegal;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench for fetch_decode_ctrl: directed cases plus a random run,
// expected PC/controls pushed to a queue per driven cycle and popped after the edge.
// Combinational outputs are checked mid-cycle against a behavioural model.
module tb_fetch_decode_ctrl;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         STALL = 1'b0;
  logic         FLUSH_E = 1'b0;
  logic [31:0]  INSTR_D = '0;
  logic [W-1:0] PCPLUS4_D = '0;
  logic [W-1:0] RD1_D = '0;
  logic [W-1:0] RD2_D = '0;
  logic [W-1:0] PC_F, PCPLUS4_F, PCBRANCH_D;
  logic         PCSRC_D;
  logic         REG_WRITE_E, MEM_TO_REG_E, MEM_WRITE_E, ALU_SRC_E, REG_DST_E, ILLEGAL_E;
  logic [3:0]   ALU_CONTROL_E;

  fetch_decode_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH_E(FLUSH_E),
    .INSTR_D(INSTR_D), .PCPLUS4_D(PCPLUS4_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .PC_F(PC_F), .PCPLUS4_F(PCPLUS4_F), .PCSRC_D(PCSRC_D), .PCBRANCH_D(PCBRANCH_D),
    .REG_WRITE_E(REG_WRITE_E), .MEM_TO_REG_E(MEM_TO_REG_E), .MEM_WRITE_E(MEM_WRITE_E),
    .ALU_SRC_E(ALU_SRC_E), .REG_DST_E(REG_DST_E), .ALU_CONTROL_E(ALU_CONTROL_E),
    .ILLEGAL_E(ILLEGAL_E)
  );

  always #5 CLK = ~CLK;

  // {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, alu_control[3:0], illegal}
  logic [9:0] ctrl_e;
  assign ctrl_e = {REG_WRITE_E, MEM_TO_REG_E, MEM_WRITE_E, ALU_SRC_E, REG_DST_E,
                   ALU_CONTROL_E, ILLEGAL_E};

  typedef struct {
    logic [W-1:0] pc;
    logic [9:0]   ctrl;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_pc;
  logic [9:0]   m_ctrl;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] model_dec(input logic [31:0] ins);
    logic [9:0] r;
    case (ins[31:26])
      6'd0: begin
`ifdef VECTOR_OPS_EN
        r = {5'b10001, ins[0], ins[3:1], 1'b0};
`else
        r = ins[0] ? 10'b00000_0000_1 : {5'b10001, 1'b0, ins[3:1], 1'b0};
`endif
      end
      6'd1:    r = 10'b10010_0000_0;
      6'd2:    r = 10'b11010_0000_0;
      6'd3:    r = 10'b00110_0000_0;
      6'd4:    r = 10'b00000_0001_0;
      default: r = 10'b00000_0000_1;
    endcase
    return r;
  endfunction

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cycle(input logic [31:0] ins, input logic [W-1:0] r1, input logic [W-1:0] r2,
                       input logic [W-1:0] p4, input logic st, input logic fl);
    logic         taken;
    logic [W-1:0] tgt;
    logic [W-1:0] nxt;
    logic [W-1:0] sext;
    exp_t         e;
    INSTR_D = ins; RD1_D = r1; RD2_D = r2; PCPLUS4_D = p4; STALL = st; FLUSH_E = fl;
    #1;
    taken = (ins[31:26] == 6'd4) && (r1 == r2);
    sext  = {{(W-16){ins[15]}}, ins[15:0]};
    tgt   = p4 + (sext << 2);
    nxt   = m_pc + W'(4);
    check("pcplus4_f", PCPLUS4_F, nxt);
    check("pcsrc_d", PCSRC_D, taken);
    check("pcbranch_d", PCBRANCH_D, tgt);
    if (!st) m_pc = taken ? tgt : nxt;
    if (fl) m_ctrl = '0;
    else if (!st) m_ctrl = model_dec(ins);
    e.pc = m_pc; e.ctrl = m_ctrl;
    sb.push_back(e);
    @(posedge CLK); #1;
    e = sb.pop_front();
    check("pc_f", PC_F, e.pc);
    check("ctrl_e", ctrl_e, e.ctrl);
  endtask

  localparam logic [31:0] ADDI = 32'h0400_0000;

  initial begin
    logic [31:0] r;
    logic [5:0]  ops [6];
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'h3F};

    #1;
    check("reset_pc", PC_F, 0);
    check("reset_ctrl", ctrl_e, 0);
    @(posedge CLK); #1;
    check("reset_hold_pc", PC_F, 0);
    RESET = 1'b0;
    m_pc = '0; m_ctrl = '0;

    for (int i = 1; i <= 3; i++) begin
      cycle(ADDI, 0, 0, 0, 1'b0, 1'b0);
      check("addi_pc", PC_F, i * 4);
    end

    cycle(32'h1000_0003, 5, 5, 32'h20, 1'b0, 1'b0);
    check("beq_taken_pc", PC_F, 32'h2C);
    cycle(32'h1000_0003, 5, 6, 32'h20, 1'b0, 1'b0);
    check("beq_not_taken_pc", PC_F, 32'h30);
    cycle(32'h1000_FFFF, 5, 5, 32'h20, 1'b0, 1'b0);
    check("beq_backward_pc", PC_F, 32'h1C);
    cycle(32'h1000_0001, 32'h8000_0005, 5, 32'h40, 1'b0, 1'b0);
    check("beq_fullwidth_pc", PC_F, 32'h20);

    cycle(32'h0800_0000, 0, 0, 0, 1'b0, 1'b0);
    check("lw_ctrl", ctrl_e, 10'b11010_0000_0);
    cycle(32'hFC00_0000, 0, 0, 0, 1'b0, 1'b0);
    check("illegal_ctrl", ctrl_e, 10'b00000_0000_1);
    cycle(32'h0000_000B, 0, 0, 0, 1'b0, 1'b0);
`ifdef VECTOR_OPS_EN
    check("rtype_vec_ctrl", ctrl_e, 10'b10001_1101_0);
`else
    check("rtype_vec_ctrl", ctrl_e, 10'b00000_0000_1);
`endif

    cycle(32'h0C00_0000, 0, 0, 0, 1'b1, 1'b0);
    check("stall_pc_hold", PC_F, 32'h2C);
    cycle(ADDI, 0, 0, 0, 1'b1, 1'b1);
    check("flush_over_stall", ctrl_e, 0);
    cycle(ADDI, 0, 0, 0, 1'b0, 1'b0);

    // Branch to the top of the address space, then wrap to zero.
    cycle(32'h1000_0001, 7, 7, 32'hFFFF_FFF8, 1'b0, 1'b0);
    check("top_pc", PC_F, 32'hFFFF_FFFC);
    cycle(ADDI, 0, 0, 0, 1'b0, 1'b0);
    check("wrap_pc", PC_F, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom();
      cycle({ops[$urandom_range(0, 5)], r[25:0]},
            W'($urandom_range(0, 3)), W'($urandom_range(0, 3)),
            W'($urandom() & 32'hFFFF_FFFC),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset in the middle of a cycle.
    cycle(32'h0800_0000, 0, 0, 0, 1'b0, 1'b0);
    #3;
    RESET = 1'b1;
    #1;
    check("async_reset_pc", PC_F, 0);
    check("async_reset_ctrl", ctrl_e, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    m_pc = '0; m_ctrl = '0;
    cycle(ADDI, 0, 0, 0, 1'b0, 1'b0);
    check("post_reset_pc", PC_F, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Front-end control slice of the 5-stage pipelined CPU.
- Holds the fetch PC register and computes PC+4 with an adder.
- Decodes the D-stage opcode into datapath controls (control unit).
- Resolves branches in Decode: branch AND equal drives PC select; a second adder forms the branch target.
- Registers the decoded controls into the D→E pipeline slot.

Parameters:
- WIDTH, 32, datapath/PC width in bits (minimum 18).

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- STALL  in  1  freeze PC register and D→E control register
- FLUSH_E  in  1  load a bubble (all controls 0) into the E-stage control register
- INSTR_D  in  32  instruction in Decode
- PCPLUS4_D  in  WIDTH  PC+4 of the Decode instruction
- RD1_D  in  WIDTH  register read data 1
- RD2_D  in  WIDTH  register read data 2
- PC_F  out  WIDTH  current fetch PC (registered)
- PCPLUS4_F  out  WIDTH  PC_F + 4 (combinational)
- PCSRC_D  out  1  branch taken (combinational)
- PCBRANCH_D  out  WIDTH  branch target (combinational)
- REG_WRITE_E, MEM_TO_REG_E, MEM_WRITE_E, ALU_SRC_E, REG_DST_E  out  1 each  registered controls
- ALU_CONTROL_E  out  4  registered ALU operation
- ILLEGAL_E  out  1  registered undefined-opcode flag

Behaviour:
- Reset (async, RESET=1):
  - PC_F=0.
  - All *_E outputs = 0.
  - Reset takes effect immediately, mid-cycle included.
  - First rising edge after release performs a normal update.
- PCPLUS4_F = PC_F + 4, modulo 2^WIDTH (carry discarded; 0xFFFFFFFC wraps to 0).
- Decode fields:
  - OP = INSTR_D[31:26]
  - SHIFT = INSTR_D[3:1]
  - VEC = INSTR_D[0]
  - imm = INSTR_D[15:0]
- Decode table (fields listed are 1; all others are 0):
  - OP=000000 R-type: REG_WRITE, REG_DST; ALU_CONTROL={VEC,SHIFT}.
  - OP=000001 ADDI: REG_WRITE, ALU_SRC; ALU_CONTROL=0000.
  - OP=000010 LW: REG_WRITE, MEM_TO_REG, ALU_SRC; ALU_CONTROL=0000.
  - OP=000011 SW: MEM_WRITE, ALU_SRC; ALU_CONTROL=0000.
  - OP=000100 BEQ: BRANCH; ALU_CONTROL=0001.
  - Any other OP: all controls 0, ILLEGAL=1. No register or memory write is ever produced for it.
- Branch resolution:
  - EQUAL = (RD1_D == RD2_D), full WIDTH compare.
  - PCSRC_D = BRANCH AND EQUAL.
  - PCBRANCH_D = PCPLUS4_D + (sign-extend(imm) << 2), modulo 2^WIDTH.
  - Negative imm gives a backward target.
- PC update on each rising edge when STALL=0:
  - PC_F ← PCSRC_D ? PCBRANCH_D : PCPLUS4_F.
  - STALL=1: PC_F holds.
- E-stage control register on each rising edge:
  - FLUSH_E=1: all *_E ← 0. Takes priority over STALL.
  - Else STALL=1: hold.
  - Else: load decoded controls.
- Latency:
  - Decoded controls appear on *_E one cycle after INSTR_D.
  - PCSRC_D and PCBRANCH_D are same-cycle.

Optional Feature:
- Macro VECTOR_OPS_EN.
  - Defined: ALU_CONTROL[3] = VEC for R-type (vector ops 1xxx).
  - Undefined: ALU_CONTROL[3] forced 0. An R-type with VEC=1 sets ILLEGAL=1 with all write controls 0.

Test Plan:
- Reset, then 3 cycles with INSTR_D=0x04000000 (ADDI), STALL=0 → PC_F = 0, 4, 8, 12.
- INSTR_D=0x10000003 (BEQ, imm=3), RD1=RD2=5, PCPLUS4_D=0x20 → PCSRC_D=1, PCBRANCH_D=0x2C; next PC_F=0x2C.
- Same BEQ with RD1=5, RD2=6 → PCSRC_D=0; next PC_F=PC+4.
- BEQ with imm=0xFFFF, PCPLUS4_D=0x20 → PCBRANCH_D=0x1C.
- INSTR_D=0x08000000 (LW) → next cycle REG_WRITE_E=1, MEM_TO_REG_E=1, ALU_SRC_E=1, others 0.
- Then INSTR_D=0xFC000000 → ILLEGAL_E=1, all others 0.
- R-type with SHIFT=101, VEC=1:
  - With VECTOR_OPS_EN: ALU_CONTROL_E=1101.
  - Without: ILLEGAL_E=1.
- FLUSH_E=1 together with STALL=1 → *_E = 0.
- Assert RESET mid-cycle → PC_F=0 immediately, before the next edge.
